// File: rtl/pingpong_rd_merge.sv
// Merges the alternating read bursts of the two ping-pong RAMs into one ordered FWFT stream.
// Optional data-sequence checker enabled by defining PINGPONG_SEQ_CHECK_EN.
module pingpong_rd_merge #(
    parameter int DATA_W     = 8,
    parameter int BURST_LEN  = 50,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              ram1_rd_en,
    input  logic              ram2_rd_en,
    input  logic [DATA_W-1:0] ram1_rd_data,
    input  logic [DATA_W-1:0] ram2_rd_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_bank,
    output logic [15:0]       word_cnt,
    input  logic              err_clr,
    output logic              rd_conflict,
    output logic              short_burst,
    output logic              overflow,
    output logic              seq_err
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int BCNT_W = $clog2(BURST_LEN + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BANK1 = 2'd1;
    localparam logic [1:0] ST_BANK2 = 2'd2;

    logic [RD_LAT-1:0] vld_pipe;
    logic [RD_LAT-1:0] bank_pipe;
    logic              cap_vld;
    logic              cap_bank;
    logic [DATA_W-1:0] cap_data;
    logic              conflict_ev;

    // RAM1 wins a conflict, so the delayed bank bit is simply "RAM1 not requesting"
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vld_pipe  <= '0;
            bank_pipe <= '0;
        end else begin
            vld_pipe[0]  <= ram1_rd_en | ram2_rd_en;
            bank_pipe[0] <= ~ram1_rd_en;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                bank_pipe[i] <= bank_pipe[i-1];
            end
        end
    end

    assign cap_vld     = vld_pipe[RD_LAT-1];
    assign cap_bank    = bank_pipe[RD_LAT-1];
    assign cap_data    = cap_bank ? ram2_rd_data : ram1_rd_data;
    assign conflict_ev = ram1_rd_en & ram2_rd_en;

    logic [1:0]        state;
    logic [BCNT_W-1:0] burst_cnt;
    logic              bank_switch;
    logic              short_ev;

    assign bank_switch = cap_vld && (state != ST_IDLE) && ((state == ST_BANK2) != cap_bank);
    assign short_ev    = bank_switch && (burst_cnt != BCNT_W'(BURST_LEN));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_IDLE;
            burst_cnt <= '0;
        end else if (cap_vld) begin
            state <= cap_bank ? ST_BANK2 : ST_BANK1;
            if ((state == ST_IDLE) || bank_switch)
                burst_cnt <= BCNT_W'(1);
            else if (burst_cnt != BCNT_W'(BURST_LEN))
                burst_cnt <= burst_cnt + BCNT_W'(1);
        end
    end

    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
    logic              bank_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_full;
    logic              do_rd;
    logic              do_wr;
    logic              ovf_ev;

    // A full FIFO still accepts a write when the head is leaving in the same cycle
    assign fifo_full = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign do_rd     = out_valid && out_ready;
    assign do_wr     = cap_vld && (!fifo_full || do_rd);
    assign ovf_ev    = cap_vld && fifo_full && !do_rd;

    always_ff @(posedge sys_clk) begin
        if (do_wr) begin
            data_mem[wr_ptr] <= cap_data;
            bank_mem[wr_ptr] <= cap_bank;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            word_cnt <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                word_cnt <= word_cnt + 16'd1;
            end
            if (do_rd)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_wr && !do_rd)
                fifo_cnt <= fifo_cnt + CNT_W'(1);
            else if (do_rd && !do_wr)
                fifo_cnt <= fifo_cnt - CNT_W'(1);
        end
    end

    assign out_valid = (fifo_cnt != '0);
    assign out_data  = out_valid ? data_mem[rd_ptr] : '0;
    assign out_bank  = out_valid ? bank_mem[rd_ptr] : 1'b0;

    // A new event wins over err_clr in the same cycle
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_conflict <= 1'b0;
            short_burst <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            rd_conflict <= (rd_conflict & ~err_clr) | conflict_ev;
            short_burst <= (short_burst & ~err_clr) | short_ev;
            overflow    <= (overflow & ~err_clr) | ovf_ev;
        end
    end

`ifdef PINGPONG_SEQ_CHECK_EN
    logic              have_ref;
    logic [DATA_W-1:0] ref_word;
    logic              seq_ev;

    // Dropped words still advance the reference so one overflow does not cascade
    assign seq_ev = cap_vld && have_ref && (cap_data != ref_word + DATA_W'(1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            have_ref <= 1'b0;
            ref_word <= '0;
            seq_err  <= 1'b0;
        end else begin
            if (cap_vld) begin
                have_ref <= 1'b1;
                ref_word <= cap_data;
            end
            seq_err <= (seq_err & ~err_clr) | seq_ev;
        end
    end
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_pingpong_rd_merge.sv
// Randomised and directed bench for pingpong_rd_merge, checked every cycle against a queue-based model.
// Define PINGPONG_SEQ_CHECK_EN for both files to exercise the sequence checker.
`timescale 1ns/100ps
module tb_pingpong_rd_merge;

    localparam int DATA_W     = 8;
    localparam int BURST_LEN  = 50;
    localparam int RD_LAT     = 1;
    localparam int FIFO_DEPTH = 8;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              ram1_rd_en = 1'b0;
    logic              ram2_rd_en = 1'b0;
    logic [DATA_W-1:0] ram1_rd_data = '0;
    logic [DATA_W-1:0] ram2_rd_data = '0;
    logic              out_ready = 1'b0;
    logic              err_clr = 1'b0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_bank;
    logic [15:0]       word_cnt;
    logic              rd_conflict;
    logic              short_burst;
    logic              overflow;
    logic              seq_err;

    pingpong_rd_merge #(
        .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .ram1_rd_en(ram1_rd_en), .ram2_rd_en(ram2_rd_en),
        .ram1_rd_data(ram1_rd_data), .ram2_rd_data(ram2_rd_data),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_bank(out_bank), .word_cnt(word_cnt), .err_clr(err_clr),
        .rd_conflict(rd_conflict), .short_burst(short_burst),
        .overflow(overflow), .seq_err(seq_err)
    );

    always #10 sys_clk = ~sys_clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus: RAM data for a strobe appears RD_LAT cycles after the strobe
    logic [DATA_W-1:0] hist1 [0:RD_LAT];
    logic [DATA_W-1:0] hist2 [0:RD_LAT];
    logic [DATA_W-1:0] cur_v1 = '0;
    logic [DATA_W-1:0] cur_v2 = '0;

    initial begin
        for (int i = 0; i <= RD_LAT; i++) begin
            hist1[i] = '0;
            hist2[i] = '0;
        end
    end

    task automatic applyStimulus(input logic e1, input logic e2,
                                 input logic [DATA_W-1:0] v1, input logic [DATA_W-1:0] v2);
        @(posedge sys_clk);
        #1;
        for (int i = RD_LAT; i > 0; i--) begin
            hist1[i] = hist1[i-1];
            hist2[i] = hist2[i-1];
        end
        hist1[0]     = v1;
        hist2[0]     = v2;
        cur_v1       = v1;
        cur_v2       = v2;
        ram1_rd_en   = e1;
        ram2_rd_en   = e2;
        ram1_rd_data = hist1[RD_LAT];
        ram2_rd_data = hist2[RD_LAT];
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, DATA_W'($urandom), DATA_W'($urandom));
    endtask

    task automatic doReset();
        @(posedge sys_clk);
        #1;
        sys_rst_n  = 1'b0;
        ram1_rd_en = 1'b0;
        ram2_rd_en = 1'b0;
        err_clr    = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    // Behavioural model: captures are scheduled RD_LAT cycles ahead, FIFO is a queue
    typedef struct { int due; bit b; logic [DATA_W-1:0] d; } pend_t;
    typedef struct { bit b; logic [DATA_W-1:0] d; } word_t;

    pend_t             m_pend[$];
    word_t             m_fifo[$];
    word_t             m_w;
    int                m_cycle = 0;
    int                m_bank = -1;
    int                m_run = 0;
    logic [15:0]       m_word_cnt = '0;
    bit                m_conf = 0, m_short = 0, m_ovf = 0, m_seq = 0;
    bit                m_have_prev = 0;
    logic [DATA_W-1:0] m_prev = '0;
    bit                ev_conf, ev_short, ev_ovf, ev_seq, m_cap;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_pend.delete();
            m_fifo.delete();
            m_cycle = 0; m_bank = -1; m_run = 0; m_word_cnt = '0;
            m_conf = 0; m_short = 0; m_ovf = 0; m_seq = 0;
            m_have_prev = 0; m_prev = '0;
        end else begin
            ev_conf = ram1_rd_en && ram2_rd_en;
            ev_short = 0; ev_ovf = 0; ev_seq = 0; m_cap = 0;
            if (m_pend.size() > 0 && m_pend[0].due == m_cycle) begin
                m_w.b = m_pend[0].b;
                m_w.d = m_pend[0].d;
                void'(m_pend.pop_front());
                m_cap = 1;
            end
            if (m_fifo.size() > 0 && out_ready)
                void'(m_fifo.pop_front());
            if (m_cap) begin
                if (m_fifo.size() < FIFO_DEPTH) begin
                    m_fifo.push_back(m_w);
                    m_word_cnt = m_word_cnt + 16'd1;
                end else
                    ev_ovf = 1;
                if (m_bank < 0) begin
                    m_bank = int'(m_w.b); m_run = 1;
                end else if (m_bank == int'(m_w.b)) begin
                    if (m_run < BURST_LEN) m_run++;
                end else begin
                    if (m_run != BURST_LEN) ev_short = 1;
                    m_bank = int'(m_w.b); m_run = 1;
                end
`ifdef PINGPONG_SEQ_CHECK_EN
                if (m_have_prev && m_w.d != DATA_W'(m_prev + 1)) ev_seq = 1;
`endif
                m_prev = m_w.d;
                m_have_prev = 1;
            end
            if (ram1_rd_en || ram2_rd_en)
                m_pend.push_back('{m_cycle + RD_LAT, !ram1_rd_en, ram1_rd_en ? cur_v1 : cur_v2});
            m_cycle++;
            m_conf  = (m_conf  && !err_clr) || ev_conf;
            m_short = (m_short && !err_clr) || ev_short;
            m_ovf   = (m_ovf   && !err_clr) || ev_ovf;
            m_seq   = (m_seq   && !err_clr) || ev_seq;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge sys_clk) begin
        if (m_fifo.size() > 0) begin
            checkOutput("out_valid", 32'(out_valid), 32'd1);
            checkOutput("out_data", 32'(out_data), 32'(m_fifo[0].d));
            checkOutput("out_bank", 32'(out_bank), 32'(m_fifo[0].b));
        end else begin
            checkOutput("out_valid", 32'(out_valid), 32'd0);
            checkOutput("out_data", 32'(out_data), 32'd0);
            checkOutput("out_bank", 32'(out_bank), 32'd0);
        end
        checkOutput("word_cnt", 32'(word_cnt), 32'(m_word_cnt));
        checkOutput("rd_conflict", 32'(rd_conflict), 32'(m_conf));
        checkOutput("short_burst", 32'(short_burst), 32'(m_short));
        checkOutput("overflow", 32'(overflow), 32'(m_ovf));
        checkOutput("seq_err", 32'(seq_err), 32'(m_seq));
    end

    logic [DATA_W:0] rec[$];

    always @(negedge sys_clk) begin
        if (sys_rst_n && out_valid && out_ready)
            rec.push_back({out_bank, out_data});
    end

    task automatic checkStream(input string name, input int n, input int first_val, input int bank_split);
        int bad = 0;
        logic [DATA_W:0] exp;
        checkOutput({name, "_len"}, 32'(rec.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            exp = {(i >= bank_split) ? 1'b1 : 1'b0, DATA_W'(first_val + i)};
            if (i >= rec.size() || rec[i] !== exp) bad++;
        end
        checkOutput({name, "_order_errors"}, 32'(bad), 32'd0);
    endtask

    int next_val;
    bit rbank;
    int run_len;
    logic [DATA_W-1:0] v;

    initial begin
        #150;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_word_cnt", 32'(word_cnt), 32'd0);
        checkOutput("reset_flags", 32'({rd_conflict, short_burst, overflow, seq_err}), 32'd0);
        #50.1;
        sys_rst_n = 1'b1;
        idleCycles(2);

        // Alternating 50-word bursts
        out_ready = 1'b1;
        rec.delete();
        for (int i = 0; i < 50; i++) applyStimulus(1'b1, 1'b0, DATA_W'(i), DATA_W'($urandom));
        for (int i = 50; i < 100; i++) applyStimulus(1'b0, 1'b1, DATA_W'($urandom), DATA_W'(i));
        idleCycles(6);
        checkStream("alt_stream", 100, 0, 50);
        checkOutput("alt_word_cnt", 32'(word_cnt), 32'd100);
        checkOutput("alt_flags", 32'({rd_conflict, short_burst, overflow, seq_err}), 32'd0);

        // Short burst then clear
        doReset();
        for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b0, DATA_W'(i), DATA_W'($urandom));
        for (int i = 30; i < 40; i++) applyStimulus(1'b0, 1'b1, DATA_W'($urandom), DATA_W'(i));
        idleCycles(4);
        checkOutput("short_set", 32'(short_burst), 32'd1);
        err_clr = 1'b1;
        idleCycles(1);
        err_clr = 1'b0;
        idleCycles(1);
        checkOutput("short_cleared", 32'(short_burst), 32'd0);

        // Back-pressure and overflow
        doReset();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, DATA_W'(i), DATA_W'($urandom));
        idleCycles(3);
        checkOutput("bp_overflow", 32'(overflow), 32'd1);
        checkOutput("bp_word_cnt", 32'(word_cnt), 32'd8);
        checkOutput("bp_valid_held", 32'(out_valid), 32'd1);
        rec.delete();
        out_ready = 1'b1;
        idleCycles(12);
        checkStream("bp_drain", 8, 0, 99);
        checkOutput("bp_empty_valid", 32'(out_valid), 32'd0);
        checkOutput("bp_empty_data", 32'(out_data), 32'd0);

        // Conflict: RAM1 wins
        doReset();
        rec.delete();
        applyStimulus(1'b1, 1'b1, 8'h11, 8'h22);
        idleCycles(4);
        checkOutput("conflict_flag", 32'(rd_conflict), 32'd1);
        checkStream("conflict_word", 1, 'h11, 99);

        // Sequence 5,6,8
        doReset();
        applyStimulus(1'b1, 1'b0, 8'd5, 8'd0);
        applyStimulus(1'b1, 1'b0, 8'd6, 8'd0);
        applyStimulus(1'b1, 1'b0, 8'd8, 8'd0);
        idleCycles(3);
`ifdef PINGPONG_SEQ_CHECK_EN
        checkOutput("seq_err_568", 32'(seq_err), 32'd1);
`else
        checkOutput("seq_err_568", 32'(seq_err), 32'd0);
`endif

        // Reset in the middle of a burst
        doReset();
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, DATA_W'(i), DATA_W'($urandom));
        sys_rst_n  = 1'b0;
        ram1_rd_en = 1'b0;
        #1;
        checkOutput("midrst_outputs",
                    32'({out_valid, out_data, out_bank, rd_conflict, short_burst, overflow, seq_err}), 32'd0);
        checkOutput("midrst_word_cnt", 32'(word_cnt), 32'd0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        for (int i = 0; i < 50; i++) applyStimulus(1'b0, 1'b1, DATA_W'($urandom), DATA_W'(100 + i));
        applyStimulus(1'b1, 1'b0, 8'd150, 8'd0);
        idleCycles(4);
        checkOutput("midrst_no_short", 32'(short_burst), 32'd0);
        checkOutput("midrst_word_cnt_after", 32'(word_cnt), 32'd51);

        // Randomised bursts, gaps, conflicts, back-pressure and flag clears
        doReset();
        next_val = 0;
        for (int r = 0; r < 30; r++) begin
            rbank   = 1'($urandom_range(0, 1));
            run_len = ($urandom_range(0, 2) == 0) ? BURST_LEN : int'($urandom_range(1, 60));
            for (int k = 0; k < run_len; k++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                err_clr   = ($urandom_range(0, 29) == 0);
                if ($urandom_range(0, 5) == 0) idleCycles(1);
                v = ($urandom_range(0, 19) == 0) ? DATA_W'($urandom) : DATA_W'(next_val);
                next_val = int'(v) + 1;
                if ($urandom_range(0, 39) == 0)
                    applyStimulus(1'b1, 1'b1, v, DATA_W'($urandom));
                else if (rbank)
                    applyStimulus(1'b0, 1'b1, DATA_W'($urandom), v);
                else
                    applyStimulus(1'b1, 1'b0, v, DATA_W'($urandom));
            end
        end
        err_clr   = 1'b0;
        out_ready = 1'b1;
        idleCycles(FIFO_DEPTH + RD_LAT + 4);
        checkOutput("rand_drained", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
